// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Purpose  : Shared types for the RAM port-B arbiter. Holds the requester tag,
//            the arbiter state encoding, the read-return pipe entry and the
//            default address/data widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    // Which requester a read return belongs to
    typedef enum logic {
        TAG_CPU = 1'b0,
        TAG_LDR = 1'b1
    } req_tag_e;

    // ARB: normal fixed-priority arbitration; LOCK: loader owns the port
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // One slot of the read-return pipe
    typedef struct packed {
        logic     valid;
        req_tag_e tag;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Purpose  : Bundles the CPU request port, the loader request port and the
//            RAM port-B signals around the arbiter.
// Ports    : slave  - arbiter view (requests/ram_rdata in, grants/returns/ram_* out)
//            master - environment view (the mirror image)
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int AW = ram_port_arbiter_pkg::DEF_AW,
    parameter int DW = ram_port_arbiter_pkg::DEF_DW
);
    // CPU (requester 0)
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    // Loader (requester 1)
    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_lock;
    logic          ldr_gnt;
    logic          ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    // RAM port B
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  ram_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output ram_addr, ram_wdata, ram_wren
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output ram_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  ram_addr, ram_wdata, ram_wren
    );

endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_rd_tag_pipe
// Purpose  : DEPTH-stage shift register of {valid, tag}. An entry pushed in
//            cycle N appears on pop in cycle N+DEPTH, matching the RAM read
//            latency so the return can be steered to its requester.
// Ports    : clk, rst_n (async active-low), push (entry in), pop (entry out)
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter_rd_tag_pipe
    import ram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t push,
    output rd_tag_t pop
);

    rd_tag_t [DEPTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares RAM data port B between the CPU load/store path and the
//            debug/program loader. CPU has fixed priority; a starvation
//            counter forces a loader grant after MAX_WAIT denied cycles; the
//            loader can lock the port for a burst. Read data is steered back
//            to the requester that issued the load, RD_LATENCY cycles later.
// Ports    : clk, CPU_RESET_n (async active-low)
//            bus (slave) - CPU/loader request ports and RAM port B
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,   // 1..2
    parameter int MAX_WAIT   = 4,   // >= 1
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic              clk,
    input  logic              CPU_RESET_n,
    ram_port_arbiter_if.slave bus
);

    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    arb_state_e    state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          cpu_gnt, ldr_gnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    rd_tag_t       rd_push, rd_pop;
    logic          cpu_ret, ldr_ret;
    logic [DW-1:0] cpu_hold, ldr_hold;

    // ------------------------------------------------------------------
    // Arbitration, next state and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        cpu_gnt      = 1'b0;
        ldr_gnt      = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;

        // No grant may be issued while reset is held, even though the
        // grant path is combinational.
        if (CPU_RESET_n) begin
            if (state == LOCK && bus.ldr_lock) begin
                ldr_gnt = bus.ldr_req;
            end else if (bus.cpu_req && bus.ldr_req) begin
                if (wait_cnt == WAIT_LIMIT) begin
                    ldr_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = bus.cpu_req;
                ldr_gnt = bus.ldr_req;
            end
        end

        // Lock is entered on a locked loader grant and held for as long as
        // ldr_lock stays high; dropping it releases the port the same cycle.
        state_nxt = (bus.ldr_lock && (ldr_gnt || state == LOCK)) ? LOCK : ARB;

        if (bus.ldr_req && !ldr_gnt) begin
            wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CW'(1);
        end else begin
            wait_cnt_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux; address/data hold their last value when idle
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_wren  = 1'b0;
        bus.ram_addr  = last_addr;
        bus.ram_wdata = last_wdata;
        rd_push       = '0;
        if (cpu_gnt) begin
            bus.ram_wren  = bus.cpu_we;
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_wdata = bus.cpu_wdata;
            rd_push.valid = ~bus.cpu_we;
            rd_push.tag   = TAG_CPU;
        end else if (ldr_gnt) begin
            bus.ram_wren  = bus.ldr_we;
            bus.ram_addr  = bus.ldr_addr;
            bus.ram_wdata = bus.ldr_wdata;
            rd_push.valid = ~bus.ldr_we;
            rd_push.tag   = TAG_LDR;
        end
    end

    // ------------------------------------------------------------------
    // Read-return routing
    // ------------------------------------------------------------------
    ram_port_arbiter_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .rst_n (CPU_RESET_n),
        .push  (rd_push),
        .pop   (rd_pop)
    );

    assign cpu_ret = rd_pop.valid && (rd_pop.tag == TAG_CPU);
    assign ldr_ret = rd_pop.valid && (rd_pop.tag == TAG_LDR);

    // Data is passed straight through on the return cycle and a copy is
    // kept so rdata stays stable until that requester's next return.
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ldr_gnt    = ldr_gnt;
    assign bus.cpu_rvalid = cpu_ret;
    assign bus.ldr_rvalid = ldr_ret;
    assign bus.cpu_rdata  = cpu_ret ? bus.ram_rdata : cpu_hold;
    assign bus.ldr_rdata  = ldr_ret ? bus.ram_rdata : ldr_hold;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge CPU_RESET_n) begin
        if (!CPU_RESET_n) begin
            state      <= ARB;
            wait_cnt   <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
            cpu_hold   <= '0;
            ldr_hold   <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            last_addr  <= bus.ram_addr;
            last_wdata <= bus.ram_wdata;
            if (cpu_ret) begin
                cpu_hold <= bus.ram_rdata;
            end
            if (ldr_ret) begin
                ldr_hold <= bus.ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench. Two arbiters (read latency 1 and 2) see the
//            same requests, each with its own RAM model. A behavioural model
//            predicts grants, RAM port values and tagged read returns every
//            cycle; directed scenarios are followed by a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 4;
    localparam int MW       = 512;

    typedef struct {
        int            due;
        bit            ldr;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct packed {
        logic          cg;
        logic          lg;
        logic          crv;
        logic [DW-1:0] crd;
        logic          lrv;
        logic [DW-1:0] lrd;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Shared stimulus
    logic          cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] cpu_addr, ldr_addr;
    logic [DW-1:0] cpu_wdata, ldr_wdata;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
    ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

    assign bus1.cpu_req   = cpu_req;   assign bus2.cpu_req   = cpu_req;
    assign bus1.cpu_we    = cpu_we;    assign bus2.cpu_we    = cpu_we;
    assign bus1.cpu_addr  = cpu_addr;  assign bus2.cpu_addr  = cpu_addr;
    assign bus1.cpu_wdata = cpu_wdata; assign bus2.cpu_wdata = cpu_wdata;
    assign bus1.ldr_req   = ldr_req;   assign bus2.ldr_req   = ldr_req;
    assign bus1.ldr_we    = ldr_we;    assign bus2.ldr_we    = ldr_we;
    assign bus1.ldr_addr  = ldr_addr;  assign bus2.ldr_addr  = ldr_addr;
    assign bus1.ldr_wdata = ldr_wdata; assign bus2.ldr_wdata = ldr_wdata;
    assign bus1.ldr_lock  = ldr_lock;  assign bus2.ldr_lock  = ldr_lock;

    ram_port_arbiter #(.RD_LATENCY(1), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) u_dut_l1 (
        .clk         (clk),
        .CPU_RESET_n (rst_n),
        .bus         (bus1)
    );

    ram_port_arbiter #(.RD_LATENCY(2), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) u_dut_l2 (
        .clk         (clk),
        .CPU_RESET_n (rst_n),
        .bus         (bus2)
    );

    // ------------------------------------------------------------------
    // RAM models: registered address; the latency-2 one adds an output reg
    // ------------------------------------------------------------------
    logic [DW-1:0] init_val [MW];
    logic [DW-1:0] ref_mem  [MW];
    logic [DW-1:0] mem1     [MW];
    logic [DW-1:0] mem2     [MW];
    logic [8:0]    a1_q, a2_q;
    logic [DW-1:0] q2_r;
    logic          preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) mem1[i] <= init_val[i];
        end else if (bus1.ram_wren) begin
            mem1[bus1.ram_addr[8:0]] <= bus1.ram_wdata;
        end
        a1_q <= bus1.ram_addr[8:0];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) mem2[i] <= init_val[i];
        end else if (bus2.ram_wren) begin
            mem2[bus2.ram_addr[8:0]] <= bus2.ram_wdata;
        end
        a2_q <= bus2.ram_addr[8:0];
        q2_r <= mem2[a2_q];
    end

    assign bus1.ram_rdata = mem1[a1_q];
    assign bus2.ram_rdata = q2_r;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model state
    // ------------------------------------------------------------------
    bit            m_locked;
    int            m_starve;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_wd;
    ret_t          q1[$], q2[$];
    logic [DW-1:0] h1c, h1l, h2c, h2l;
    int            cyc = 0;
    bit            last_gc, last_gl;
    obs_t          obs1, obs2;

    task automatic check_dut(input string nm, input obs_t o, input logic wren,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                             input bit egc, input bit egl, input bit ewren,
                             input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
                             input ret_t q[$], input logic [DW-1:0] hc, input logic [DW-1:0] hl,
                             output bit cv, output bit lv,
                             output logic [DW-1:0] cd, output logic [DW-1:0] ld);
        cv = 1'b0; lv = 1'b0; cd = hc; ld = hl;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].ldr) begin lv = 1'b1; ld = q[0].data; end
            else          begin cv = 1'b1; cd = q[0].data; end
        end
        chk({nm, " cpu_gnt"},    32'(o.cg),  32'(egc));
        chk({nm, " ldr_gnt"},    32'(o.lg),  32'(egl));
        chk({nm, " ram_wren"},   32'(wren),  32'(ewren));
        chk({nm, " ram_addr"},   32'(addr),  32'(eaddr));
        chk({nm, " ram_wdata"},  32'(wd),    32'(ewd));
        chk({nm, " cpu_rvalid"}, 32'(o.crv), 32'(cv));
        chk({nm, " cpu_rdata"},  32'(o.crd), 32'(cd));
        chk({nm, " ldr_rvalid"}, 32'(o.lrv), 32'(lv));
        chk({nm, " ldr_rdata"},  32'(o.lrd), 32'(ld));
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return just after the next rising edge so the caller can drive inputs.
    task automatic cycle();
        bit            gc, gl, ewren, cv, lv;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd, cd, ld;
        ret_t          r;
        @(negedge clk);
        gc = 1'b0; gl = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0; m_starve = 0; m_last_addr = '0; m_last_wd = '0;
            q1.delete(); q2.delete();
            h1c = '0; h1l = '0; h2c = '0; h2l = '0;
        end else if (m_locked && ldr_lock) begin
            gl = ldr_req;
        end else if (cpu_req && ldr_req) begin
            if (m_starve == MAX_WAIT) gl = 1'b1; else gc = 1'b1;
        end else begin
            gc = cpu_req;
            gl = ldr_req;
        end
        ewren = gc ? cpu_we    : (gl ? ldr_we    : 1'b0);
        eaddr = gc ? cpu_addr  : (gl ? ldr_addr  : m_last_addr);
        ewd   = gc ? cpu_wdata : (gl ? ldr_wdata : m_last_wd);

        obs1 = {bus1.cpu_gnt, bus1.ldr_gnt, bus1.cpu_rvalid, bus1.cpu_rdata, bus1.ldr_rvalid, bus1.ldr_rdata};
        obs2 = {bus2.cpu_gnt, bus2.ldr_gnt, bus2.cpu_rvalid, bus2.cpu_rdata, bus2.ldr_rvalid, bus2.ldr_rdata};

        check_dut("L1", obs1, bus1.ram_wren, bus1.ram_addr, bus1.ram_wdata,
                  gc, gl, ewren, eaddr, ewd, q1, h1c, h1l, cv, lv, cd, ld);
        if (cv || lv) void'(q1.pop_front());
        h1c = cd; h1l = ld;
        check_dut("L2", obs2, bus2.ram_wren, bus2.ram_addr, bus2.ram_wdata,
                  gc, gl, ewren, eaddr, ewd, q2, h2c, h2l, cv, lv, cd, ld);
        if (cv || lv) void'(q2.pop_front());
        h2c = cd; h2l = ld;

        if (rst_n) begin
            m_last_addr = eaddr;
            m_last_wd   = ewd;
            if ((gc || gl) && !ewren) begin
                r.ldr  = gl;
                r.data = ref_mem[eaddr[8:0]];
                r.due  = cyc + 1; q1.push_back(r);
                r.due  = cyc + 2; q2.push_back(r);
            end
            if (ewren) ref_mem[eaddr[8:0]] = ewd;
            if (ldr_req && !gl) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
            else                m_starve = 0;
            m_locked = ldr_lock && (gl || m_locked);
        end
        last_gc = gc;
        last_gl = gl;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_reqs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : main
        logic [4:0] pat1, pat2;
        int         denied;

        for (int i = 0; i < MW; i++) init_val[i] = DW'($urandom);
        init_val[9'h010] = 16'hBEEF;
        for (int i = 0; i < MW; i++) ref_mem[i] = init_val[i];
        idle_reqs();
        rst_n   = 1'b0;
        preload = 1'b1;
        cycle();
        preload = 1'b0;
        rst_n   = 1'b1;
        cycle();

        // 1: reset in the middle of a load discards its return
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        cycle();
        chk("t1 gnt before reset", 32'(obs1.cg), 32'd1);
        rst_n = 1'b0;
        ldr_req = 1'b1;
        cycle();
        chk("t1 cpu_gnt in reset", 32'(obs1.cg), 32'd0);
        chk("t1 rvalid in reset", 32'(obs1.crv), 32'd0);
        cycle();
        chk("t1 l2 rvalid in reset", 32'(obs2.crv), 32'd0);
        idle_reqs();
        rst_n = 1'b1;
        repeat (3) begin
            cycle();
            chk("t1 no rvalid after", 32'(obs1.crv | obs2.crv), 32'd0);
        end

        // 2: CPU load of 0x0010
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cycle();
        chk("t2 cpu_gnt", 32'(obs1.cg), 32'd1);
        cpu_req = 1'b0;
        cycle();
        chk("t2 l1 rvalid", 32'(obs1.crv), 32'd1);
        chk("t2 l1 rdata", 32'(obs1.crd), 32'hBEEF);
        cycle();
        chk("t2 l2 rvalid", 32'(obs2.crv), 32'd1);
        chk("t2 l2 rdata", 32'(obs2.crd), 32'hBEEF);

        // 3: both requesting every cycle -> LDR forced on the 5th cycle
        cpu_req = 1'b1; cpu_addr = 16'h0011;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0012;
        pat1 = '0; pat2 = '0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            pat1 = {pat1[3:0], obs1.lg};
            pat2 = {pat2[3:0], obs2.lg};
        end
        chk("t3 l1 ldr grant pattern", 32'(pat1), 32'b00001);
        chk("t3 l2 ldr grant pattern", 32'(pat2), 32'b00001);
        cycle();
        chk("t3 cpu wins after forced grant", 32'(obs1.cg), 32'd1);
        idle_reqs();
        repeat (3) cycle();

        // 4: locked loader burst stores while CPU waits
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b1;
        denied = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                ldr_addr  = 16'h0100 + AW'(k);
                ldr_wdata = DW'(k + 1);
            end else begin
                ldr_req = 1'b0;
            end
            if (k == 5) ldr_lock = 1'b0;
            cpu_req = (k >= 1); cpu_we = 1'b0; cpu_addr = 16'h0040;
            cycle();
            if (k >= 1 && k <= 4 && !obs1.cg) denied++;
            if (k == 5) chk("t4 cpu gnt on unlock", 32'(obs1.cg), 32'd1);
        end
        chk("t4 cpu denied cycles", 32'(denied), 32'd4);
        idle_reqs();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0100 + AW'(k);
            end else begin
                ldr_req = 1'b0;
            end
            cycle();
            if (k > 0) chk("t4 readback", 32'(obs1.lrd), 32'(k));
        end
        idle_reqs();
        repeat (2) cycle();

        // 5: interleaved loads, latency-2 instance returns in issue order
        for (int k = 0; k < 6; k++) begin
            cpu_req = (k == 0 || k == 2); cpu_we = 1'b0;
            cpu_addr = (k == 0) ? 16'h0020 : 16'h0022;
            ldr_req = (k == 1); ldr_we = 1'b0; ldr_addr = 16'h0021;
            cycle();
            chk("t5 cpu rvalid", 32'(obs2.crv), 32'(k == 2 || k == 4));
            chk("t5 ldr rvalid", 32'(obs2.lrv), 32'(k == 3));
            if (k == 2) chk("t5 cpu data 0x20", 32'(obs2.crd), 32'(init_val[9'h020]));
            if (k == 3) chk("t5 ldr data 0x21", 32'(obs2.lrd), 32'(init_val[9'h021]));
            if (k == 4) chk("t5 cpu data 0x22", 32'(obs2.crd), 32'(init_val[9'h022]));
        end
        idle_reqs();

        // 6: store then load of the same address
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h1234;
        cycle();
        cpu_we = 1'b0;
        cycle();
        cpu_req = 1'b0;
        cycle();
        chk("t6 l1 rdata", 32'(obs1.crd), 32'h1234);
        cycle();
        chk("t6 l2 rdata", 32'(obs2.crd), 32'h1234);

        // Random traffic; requests stay stable until granted
        last_gc = 1'b0; last_gl = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req || last_gc) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, 63));
                cpu_wdata = DW'($urandom);
            end
            if (!ldr_req || last_gl) begin
                ldr_req   = ($urandom_range(0, 2) != 0);
                ldr_we    = 1'($urandom_range(0, 1));
                ldr_addr  = AW'($urandom_range(0, 63));
                ldr_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 9) == 0) ldr_lock = ~ldr_lock;
            cycle();
        end
        idle_reqs();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
